dmem_unit: RTL



---
 rtl/dmem_pkg.sv | 35 +++
 rtl/dmem_array.sv | 62 ++++++
 rtl/dmem_unit.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory unit and the processor it serves:
//   - default address/data widths (match the processor lw_address / regfile)
//   - FSM state encoding for dmem_unit
//   - preload operand constants and a lookup helper used by dmem_array
// -----------------------------------------------------------------------------
package dmem_pkg;

  localparam int DMEM_ADDR_W = 8;
  localparam int DMEM_DATA_W = 8;

  // Program operands present in storage after every reset.
  localparam logic [7:0] DMEM_INIT0 = 8'hEC;  // -20
  localparam logic [7:0] DMEM_INIT1 = 8'h0A;  //  10
  localparam logic [7:0] DMEM_INIT2 = 8'h02;  //   2

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } dmem_state_e;

  // Reset value of storage word idx.
  function automatic logic [7:0] dmem_init_word(input int idx);
    case (idx)
      0:       return DMEM_INIT0;
      1:       return DMEM_INIT1;
      2:       return DMEM_INIT2;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/dmem_array.sv
// -----------------------------------------------------------------------------
// dmem_array
// Resettable DEPTH x DATA_W storage, preloaded on reset from dmem_pkg.
// One synchronous write port, one combinational read port (the caller
// registers the read data).
// Ports:
//   clk      in   clock, posedge
//   rst_n    in   asynchronous active-low reset (restores preload values)
//   we_i     in   write enable
//   waddr_i  in   write word index
//   wdata_i  in   write data
//   raddr_i  in   read word index
//   rdata_o  out  read data (0 for an index with no storage word behind it)
// -----------------------------------------------------------------------------
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8,
  parameter int IDX_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  // Words live in per-index registers so each has its own reset value;
  // they are gathered into one flat vector for the read mux.
  logic [DEPTH*DATA_W-1:0] mem_flat;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
      localparam logic [DATA_W-1:0] INIT = DATA_W'(dmem_init_word(gi));
      logic [DATA_W-1:0] word_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          word_q <= INIT;
        end else if (we_i && (waddr_i == IDX_W'(gi))) begin
          word_q <= wdata_i;
        end
      end

      assign mem_flat[gi*DATA_W +: DATA_W] = word_q;
    end
  endgenerate

  // Compare-based mux so a non-power-of-2 DEPTH never indexes past the end.
  always_comb begin
    rdata_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (raddr_i == IDX_W'(i)) begin
        rdata_o = mem_flat[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/dmem_unit.sv
// -----------------------------------------------------------------------------
// dmem_unit
// Multi-cycle data memory behind the processor memory stage. Serves one
// lw/sw at a time: IDLE -> WAIT (LATENCY cycles) -> ACCESS -> RESP.
// Optional build macro: DMEM_BOUNDS_CHECK_EN
//   defined   : req_addr >= DEPTH gives resp_err=1, no write, rdata 0
//   undefined : address wraps modulo DEPTH (DEPTH must be a power of 2),
//               resp_err is constant 0
// Ports:
//   clk           in   clock, posedge
//   rst_n         in   asynchronous active-low reset
//   req_valid_i   in   request present
//   req_ready_o   out  request accepted this cycle if valid (IDLE only)
//   req_we_i      in   1 = store, 0 = load
//   req_addr_i    in   word address
//   req_wdata_i   in   store data
//   resp_valid_o  out  response present (held until consumed)
//   resp_ready_i  in   response consumed
//   resp_rdata_o  out  load data, 0 for stores
//   resp_err_o    out  address error
// -----------------------------------------------------------------------------
module dmem_unit
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = DMEM_ADDR_W,
  parameter int DATA_W  = DMEM_DATA_W,
  parameter int DEPTH   = 16,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [DATA_W-1:0] resp_rdata_o,
  output logic              resp_err_o
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  dmem_state_e       state_q, state_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;

  logic              in_range;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

`ifdef DMEM_BOUNDS_CHECK_EN
  // One extra bit so DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  assign in_range = ({1'b0, addr_q} < DEPTH_L);
`else
  // Only the low index bits select a word; the rest wrap away.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_q;
  assign in_range       = 1'b1;
`endif

  dmem_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (mem_we),
    .waddr_i (addr_q[IDX_W-1:0]),
    .wdata_i (wdata_q),
    .raddr_i (addr_q[IDX_W-1:0]),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      wait_cnt_q   <= 4'd0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    mem_we       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          we_d       = req_we_i;
          addr_d     = req_addr_i;
          wdata_d    = req_wdata_i;
          wait_cnt_d = WAIT_INIT;
          state_d    = (LATENCY > 0) ? S_WAIT : S_ACCESS;
        end
      end

      S_WAIT: begin
        if (wait_cnt_q == 4'd0) begin
          state_d = S_ACCESS;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end

      S_ACCESS: begin
        mem_we       = we_q && in_range;
        resp_rdata_d = (we_q || !in_range) ? '0 : mem_rdata;
        resp_err_d   = !in_range;
        resp_valid_d = 1'b1;
        state_d      = S_RESP;
      end

      S_RESP: begin
        if (resp_ready_i) begin
          resp_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Ready is a pure state decode, so a retiring response and a new
  // acceptance can never share a cycle.
  assign req_ready_o  = (state_q == S_IDLE);
  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = resp_rdata_q;
  assign resp_err_o   = resp_err_q;

endmodule
